// File: rtl/run_ctrl_if.sv
// run_ctrl_if: groups the run-control, configuration, core-feedback and
// status/statistics signals of run_ctrl into one bundle.
//   master : drives start/abort/prog_sel, cfg_we/cfg_idx/cfg_addr and the
//            core feedback halt_in/taken_in; observes status and counters.
//   slave  : the controller side (run_ctrl).
interface run_ctrl_if #(
  parameter int NUM_PROGS = 4,
  parameter int ADDR_W    = 9,
  parameter int CNT_W     = 16
) ();
  localparam int SEL_W = $clog2(NUM_PROGS);

  logic              start;
  logic              abort;
  logic [SEL_W-1:0]  prog_sel;
  logic              cfg_we;
  logic [SEL_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_addr;
  logic              halt_in;
  logic              taken_in;
  logic              core_start;
  logic [ADDR_W-1:0] start_addr;
  logic              run;
  logic              done;
  logic              timeout;
  logic              bad_sel;
  logic [CNT_W-1:0]  instr_count;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  branch_count;

  modport master (
    output start, abort, prog_sel, cfg_we, cfg_idx, cfg_addr, halt_in, taken_in,
    input  core_start, start_addr, run, done, timeout, bad_sel,
           instr_count, cycle_count, branch_count
  );

  modport slave (
    input  start, abort, prog_sel, cfg_we, cfg_idx, cfg_addr, halt_in, taken_in,
    output core_start, start_addr, run, done, timeout, bad_sel,
           instr_count, cycle_count, branch_count
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl: program run controller for a small core.
// Selects one of NUM_PROGS entry addresses from a writable table, holds the
// core in a one-cycle LOAD (core_start) and then supervises the RUN phase
// until halt (DONE), watchdog expiry (FAULT) or abort (IDLE), collecting
// saturating instruction/cycle/branch statistics.
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : run_ctrl_if.slave (control, configuration, status, counters)
module run_ctrl #(
  parameter int NUM_PROGS   = 4,
  parameter int ADDR_W      = 9,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_PROGS);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W+1)'(NUM_PROGS);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t            r_state;
  logic              r_core_start;
  logic              r_run;
  logic              r_done;
  logic              r_timeout;
  logic              r_bad_sel;
  logic [ADDR_W-1:0] r_start_addr;
  logic [CNT_W-1:0]  r_instr_cnt;
  logic [CNT_W-1:0]  r_cycle_cnt;
  logic [CNT_W-1:0]  r_branch_cnt;
  // Watchdog runs on its own timer so a narrow, saturated cycle counter
  // can never mask the timeout.
  logic [TMR_W-1:0]  r_tmr;
  logic [ADDR_W-1:0] r_tbl [NUM_PROGS];

  logic              w_sel_ok;
  logic [ADDR_W-1:0] w_sel_addr;

  // Saturating increment used by all statistics counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic en);
    if (en && (v != CNT_MAX)) begin
      sat_inc = v + CNT_W'(1);
    end else begin
      sat_inc = v;
    end
  endfunction

  // Program-select decode: range check and table read (old entry, so a
  // same-cycle table write cannot affect the start being accepted).
  always_comb begin
    w_sel_ok   = ({1'b0, bus.prog_sel} < SEL_LIM);
    w_sel_addr = {ADDR_W{1'b0}};
    for (int i = 0; i < NUM_PROGS; i++) begin
      if (bus.prog_sel == SEL_W'(i)) begin
        w_sel_addr = r_tbl[i];
      end else begin
        w_sel_addr = w_sel_addr;
      end
    end
  end

  // Controller FSM with registered status outputs, counters and entry table.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_core_start <= 1'b0;
      r_run        <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_bad_sel    <= 1'b0;
      r_start_addr <= {ADDR_W{1'b0}};
      r_instr_cnt  <= {CNT_W{1'b0}};
      r_cycle_cnt  <= {CNT_W{1'b0}};
      r_branch_cnt <= {CNT_W{1'b0}};
      r_tmr        <= {TMR_W{1'b0}};
      for (int i = 0; i < NUM_PROGS; i++) begin
        r_tbl[i] <= {ADDR_W{1'b0}};
      end
    end else begin
      r_bad_sel <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (bus.start && w_sel_ok) begin
            r_state      <= S_LOAD;
            r_core_start <= 1'b1;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_start_addr <= w_sel_addr;
            r_instr_cnt  <= {CNT_W{1'b0}};
            r_cycle_cnt  <= {CNT_W{1'b0}};
            r_branch_cnt <= {CNT_W{1'b0}};
            r_tmr        <= {TMR_W{1'b0}};
          end else if (bus.start) begin
            r_bad_sel <= 1'b1;
          end
          for (int i = 0; i < NUM_PROGS; i++) begin
            if (bus.cfg_we && (bus.cfg_idx == SEL_W'(i))) begin
              r_tbl[i] <= bus.cfg_addr;
            end
          end
        end
        S_LOAD: begin
          r_core_start <= 1'b0;
          if (bus.abort) begin
            r_state <= S_IDLE;
          end else begin
            r_state <= S_RUN;
            r_run   <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.abort) begin
            r_state <= S_IDLE;
            r_run   <= 1'b0;
          end else begin
            r_instr_cnt  <= sat_inc(r_instr_cnt, 1'b1);
            r_cycle_cnt  <= sat_inc(r_cycle_cnt, 1'b1);
            r_branch_cnt <= sat_inc(r_branch_cnt, bus.taken_in);
            // Halt has priority over a simultaneous watchdog expiry.
            if (bus.halt_in) begin
              r_state <= S_DONE;
              r_run   <= 1'b0;
              r_done  <= 1'b1;
            end else if (r_tmr == TMR_LAST) begin
              r_state   <= S_FAULT;
              r_run     <= 1'b0;
              r_timeout <= 1'b1;
            end else begin
              r_tmr <= r_tmr + TMR_W'(1);
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_core_start <= 1'b0;
          r_run        <= 1'b0;
          r_done       <= 1'b0;
          r_timeout    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_start   = r_core_start;
  assign bus.start_addr   = r_start_addr;
  assign bus.run          = r_run;
  assign bus.done         = r_done;
  assign bus.timeout      = r_timeout;
  assign bus.bad_sel      = r_bad_sel;
  assign bus.instr_count  = r_instr_cnt;
  assign bus.cycle_count  = r_cycle_cnt;
  assign bus.branch_count = r_branch_cnt;
endmodule
